// File: rtl/explored_ram_arbiter_pkg.sv
// Shared pathfinding types: explored-table geometry, map_node and node_info records.
// Latency: n/a (types, constants and a pure address-clamp helper only).
// Backpressure: n/a.
package explored_ram_arbiter_pkg;

    // Explored-table address width and default table depth.
    localparam int ADDR_W    = 9;
    localparam int MAX_NODES = 255;

    typedef logic [ADDR_W-1:0] node_addr_t;

    // Grid coordinate of one map cell.
    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
    } map_node_t;

    // One explored-table entry, 272 bits wide.
    typedef struct packed {
        map_node_t          node;        // 16
        map_node_t          parent;      // 16
        logic [31:0]        g_cost;      // 32
        logic [31:0]        h_cost;      // 32
        logic [31:0]        f_cost;      // 32
        logic [15:0]        visit_cnt;   // 16
        map_node_t [7:0]    neighbours;  // 128
    } node_info_t;

    // Addresses beyond the populated table are folded onto entry 0 so a
    // stray search index can never read past the end of the RAM.
    function automatic node_addr_t clamp_addr(input node_addr_t addr, input int unsigned limit);
        return (32'(addr) >= limit) ? '0 : addr;
    endfunction

endpackage

// File: rtl/explored_ram_arbiter_if.sv
// Bundle of requester, writer and RAM-side signals around the explored-table arbiter.
// Latency: n/a (wiring only). slave = arbiter side, master = requesters/RAM side.
// Backpressure: reads by level request + one-hot grant; writes by level request + wr_ack pulse.
interface explored_ram_arbiter_if #(
    parameter int N_REQ = 3
);
    import explored_ram_arbiter_pkg::*;

    logic [N_REQ-1:0]             rd_req;
    logic [N_REQ-1:0][ADDR_W-1:0] rd_addr;
    logic [N_REQ-1:0]             rd_grant;
    logic [N_REQ-1:0]             rd_valid;
    logic                         wr_req;
    node_addr_t                   wr_addr;
    node_info_t                   wr_data;
    logic                         wr_ack;
    node_addr_t                   ram_rd_addr;
    logic                         ram_we;
    node_addr_t                   ram_wr_addr;
    node_info_t                   ram_wr_data;
    logic                         timeout_err;

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_grant, rd_valid, wr_ack, ram_rd_addr, ram_we,
               ram_wr_addr, ram_wr_data, timeout_err
    );

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_grant, rd_valid, wr_ack, ram_rd_addr, ram_we,
               ram_wr_addr, ram_wr_data, timeout_err
    );

endinterface

// File: rtl/explored_ram_arbiter_rr_pick.sv
// Round-robin pick: one-hot of the first set req bit at or after ptr, wrapping to 0.
// Latency: purely combinational. Ports: req (eligible requests), ptr (start index), pick (one-hot or zero).
// Backpressure: none; the caller decides when the pick is consumed.
module explored_ram_arbiter_rr_pick #(
    parameter int N_REQ = 3,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] pick
);

    logic found;

    // Walk offsets from ptr; the inner loop keeps every bit index constant.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && req[i] && (i == (int'(ptr) + off) % N_REQ)) begin
                    pick[i] = 1'b1;
                    found   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/explored_ram_arbiter.sv
// Arbitrates the explored-table RAM between N_REQ read owners and one writer.
// Latency: grant 1 cycle after request; rd_valid 1 cycle after each owned cycle; write 1 cycle after wr_req.
// Backpressure: writes stall (no wr_ack) for a whole read ownership; grants revoked after HOLD_LIMIT cycles.
// Ports: clk, reset_n (async active-low), bus (slave modport: requesters, writer, RAM side, timeout_err).
module explored_ram_arbiter #(
    parameter int MAX_NODES  = explored_ram_arbiter_pkg::MAX_NODES,
    parameter int N_REQ      = 3,
    parameter int HOLD_LIMIT = 1024
) (
    input  logic                    clk,
    input  logic                    reset_n,
    explored_ram_arbiter_if.slave   bus
);
    import explored_ram_arbiter_pkg::*;

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HC_W  = $clog2(HOLD_LIMIT + 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] READ_OWN = 2'd1;
    localparam logic [1:0] WRITE    = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] pick;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] revoked;
    logic [N_REQ-1:0] rd_valid_q;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] ptr_after;
    logic [HC_W-1:0]  hold_cnt;
    logic             timeout_q;
    logic             owner_req;
    logic             hold_expired;
    node_addr_t       sel_addr;

    // A requester whose grant timed out stays excluded until it drops its request.
    assign eligible = bus.rd_req & ~revoked;

    explored_ram_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req  (eligible),
        .ptr  (rr_ptr),
        .pick (pick)
    );

    // Owner index and its address; other requesters' addresses never reach the RAM.
    always_comb begin
        grant_idx = '0;
        sel_addr  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = PTR_W'(i);
                sel_addr  = bus.rd_addr[i];
            end
        end
    end

    assign ptr_after    = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    assign owner_req    = |(bus.rd_req & grant);
    assign hold_expired = (hold_cnt == HC_W'(HOLD_LIMIT - 1));

    // The writer wins in IDLE; READ_OWN always passes through IDLE before the next grant.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.wr_req) begin
                    state_nxt = WRITE;
                end else if (|eligible) begin
                    state_nxt = READ_OWN;
                end
            end
            READ_OWN: begin
                if (!owner_req || hold_expired) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant      <= '0;
            revoked    <= '0;
            rd_valid_q <= '0;
            rr_ptr     <= '0;
            hold_cnt   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            timeout_q <= 1'b0;
            // Every owned cycle issues one RAM read whose data lands a cycle later.
            rd_valid_q <= (state == READ_OWN) ? grant : '0;
            revoked    <= revoked & bus.rd_req;
            case (state)
                IDLE: begin
                    hold_cnt <= '0;
                    if (!bus.wr_req && |eligible) begin
                        grant <= pick;
                    end
                end
                READ_OWN: begin
                    if (!owner_req) begin
                        grant  <= '0;
                        rr_ptr <= ptr_after;
                    end else if (hold_expired) begin
                        grant     <= '0;
                        rr_ptr    <= ptr_after;
                        timeout_q <= 1'b1;
                        revoked   <= (revoked & bus.rd_req) | grant;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Write-side outputs are gated by state so reset silences them immediately.
    assign bus.rd_grant    = grant;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.wr_ack      = (state == WRITE);
    assign bus.ram_we      = (state == WRITE);
    assign bus.ram_wr_addr = (state == WRITE) ? bus.wr_addr : '0;
    assign bus.ram_wr_data = (state == WRITE) ? bus.wr_data : '0;
    assign bus.ram_rd_addr = (state == READ_OWN) ? clamp_addr(sel_addr, MAX_NODES) : '0;
    assign bus.timeout_err = timeout_q;

endmodule

// File: doc/explored_ram_arbiter.md
EXPLORED_RAM_ARBITER -- requirements
Module: explored_ram_arbiter

Interface
REQ-001 SHALL take parameters: MAX_NODES, default 255, explored-table depth; N_REQ, default 3, number of read requesters (0 child search, 1 parent search, 2 host readback); HOLD_LIMIT, default 1024, maximum cycles a read grant is held.
REQ-002 SHALL have ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rd_req  in  N_REQ  per-requester read-ownership request, level.
- rd_addr  in  N_REQ x 9  per-requester read address.
- rd_grant  out  N_REQ  one-hot current read owner.
- rd_valid  out  N_REQ  RAM data on ram_rd_data is valid for that requester.
- wr_req  in  1  write request from expansion engine, level.
- wr_addr  in  9  write address.
- wr_data  in  272  node_info write data.
- wr_ack  out  1  one-cycle pulse: write performed.
- ram_rd_addr  out  9  to RAM read_address.
- ram_we  out  1  to RAM write_enable.
- ram_wr_addr  out  9  to RAM write_address.
- ram_wr_data  out  272  to RAM write_data.
- timeout_err  out  1  one-cycle pulse: grant forcibly revoked.

Function
REQ-003 SHALL implement states IDLE, READ_OWN, WRITE.
REQ-004 In IDLE with wr_req=1, SHALL go to WRITE regardless of rd_req (writer wins simultaneous requests in IDLE).
REQ-005 In IDLE with wr_req=0 and any rd_req, SHALL go to READ_OWN, granting the first requesting index at or after rr_ptr, wrapping N_REQ-1 -> 0; rd_grant asserted the following cycle (one-cycle grant latency).
REQ-006 WRITE SHALL last exactly one cycle: ram_we=1, ram_wr_addr/ram_wr_data = wr_addr/wr_data captured in that cycle, wr_ack=1; then return to IDLE.
REQ-007 Back-to-back wr_req SHALL yield at most one write every 2 cycles; wr_req held after wr_ack is a new request.
REQ-008 In READ_OWN, ram_rd_addr SHALL combinationally follow rd_addr of the granted index; other indices' addresses SHALL be ignored.
REQ-009 rd_valid[g] SHALL assert one cycle after each READ_OWN cycle, matching the RAM's 1-cycle registered read; rd_valid SHALL be zero for non-owners.
REQ-010 Ownership SHALL persist while rd_req[g]=1; writes SHALL be stalled (wr_ack=0, ram_we=0) for the entire ownership.
REQ-011 On rd_req[g]=0 in READ_OWN, SHALL drop rd_grant next cycle, set rr_ptr = (g+1) mod N_REQ, return to IDLE; at least one IDLE cycle between grants.
REQ-012 A hold counter SHALL count READ_OWN cycles; on reaching HOLD_LIMIT, SHALL revoke grant, pulse timeout_err, advance rr_ptr, go to IDLE; that requester is not re-granted until it has deasserted rd_req for at least one cycle.
REQ-013 rd_addr values >= MAX_NODES SHALL be forwarded as 0.
REQ-014 ram_we SHALL be 0 outside WRITE; ram_rd_addr SHALL be 0 in IDLE and WRITE.

Reset
REQ-015 On reset_n=0, SHALL immediately: state=IDLE, rd_grant=0, rd_valid=0, wr_ack=0, ram_we=0, timeout_err=0, rr_ptr=0, hold counter=0, revoked flags cleared.
REQ-016 Reset asserted mid-WRITE SHALL suppress ram_we that cycle; mid-READ_OWN SHALL drop grant with no rd_valid afterwards.

Structure
REQ-017 node_info, map_node, MAX_NODES and address width 9 SHALL live in a shared pathfinding package imported by this block and the explored RAM/search blocks.
REQ-018 Round-robin selection SHALL be one sub-module, rr_pick (inputs rd_req, rr_ptr; output one-hot pick).

Verification
REQ-019 rd_req=3'b011 in IDLE, rr_ptr=0 -> rd_grant=3'b001 next cycle; release -> rd_grant=3'b010 after one IDLE cycle.
REQ-020 wr_req=1 and rd_req=3'b001 same IDLE cycle -> wr_ack pulse, ram_we=1 with wr_addr=5; grant 3'b001 two cycles later.
REQ-021 Owner 1 reads addr 0..3 -> rd_valid[1] one cycle after each address, data equals written entries; rd_valid[0]=rd_valid[2]=0.
REQ-022 Owner 0 holds req with HOLD_LIMIT=16 -> timeout_err pulse after 16 cycles, grant revoked, pending requester 2 granted next.
REQ-023 wr_req during ownership -> no ram_we until release; write completes in first IDLE after release.
REQ-024 reset_n low during WRITE and during READ_OWN -> all outputs 0 asynchronously, rr_ptr=0 after release.
